ysyx_23060332_ifu: RTL and testbench



---
 rtl/ysyx_23060332_ifu_pkg.sv | 35 +++
 rtl/ysyx_23060332_pc_reg.sv | 36 +++
 rtl/ysyx_23060332_ifu.sv | 103 ++++++++++
 tb/tb_ysyx_23060332_ifu.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060332_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: bus widths, reset constants,
// FSM state encoding and state-to-handshake decode helpers.
package ysyx_23060332_ifu_pkg;

   localparam int unsigned INST_BUS_W      = 32;
   localparam int unsigned INST_ADDR_BUS_W = 32;

   typedef logic [INST_BUS_W-1:0]      inst_bus_t;
   typedef logic [INST_ADDR_BUS_W-1:0] inst_addr_bus_t;

   localparam inst_addr_bus_t RESET_PC_DEFAULT = 32'h8000_0000;
   localparam inst_bus_t      INST_NOP         = 32'h0000_0013;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_OUT   = 3'd3,
      S_FLUSH = 3'd4
   } ifu_state_e;

   function automatic logic drives_req(input ifu_state_e s);
      return s == S_REQ;
   endfunction

   // S_FLUSH must still accept the response so the stale beat is drained.
   function automatic logic takes_rsp(input ifu_state_e s);
      return (s == S_WAIT) || (s == S_FLUSH);
   endfunction

   function automatic logic presents_inst(input ifu_state_e s);
      return s == S_OUT;
   endfunction

endpackage

// File: rtl/ysyx_23060332_pc_reg.sv
// Program counter: reset load, +4 advance, word-aligned redirect load and a
// one-cycle pulse flagging a misaligned redirect target.
module ysyx_23060332_pc_reg
   import ysyx_23060332_ifu_pkg::*;
#(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            advance,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_addr,
   output logic [XLEN-1:0] pc,
   output logic            misalign
);

   logic [XLEN-1:0] redirect_aligned;

   assign redirect_aligned = {redirect_addr[XLEN-1:2], 2'b00};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc       <= RESET_PC;
         misalign <= 1'b0;
      end else begin
         misalign <= redirect_valid && (redirect_addr[1:0] != 2'b00);
         if (redirect_valid) begin
            pc <= redirect_aligned;
         end else if (advance) begin
            pc <= pc + XLEN'(4);
         end
      end
   end

endmodule

// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch unit: single-outstanding imem fetch FSM, instruction buffer
// towards the IDU, and redirect handling that squashes stale fetches.
module ysyx_23060332_ifu
   import ysyx_23060332_ifu_pkg::*;
#(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   output logic            imem_rsp_ready,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst_o,
   output logic [XLEN-1:0] inst_addr,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_addr,
   output logic            fetch_misalign
);

   ifu_state_e      state, state_next;
   logic [XLEN-1:0] pc;
   logic            req_hs, rsp_hs, out_hs, pc_advance, capture;

   assign req_hs     = imem_req_valid && imem_req_ready;
   assign rsp_hs     = imem_rsp_valid && imem_rsp_ready;
   assign out_hs     = inst_valid && inst_ready;
   assign pc_advance = (state == S_OUT) && out_hs && !redirect_valid;
   assign capture    = (state == S_WAIT) && rsp_hs && !redirect_valid;

   // The request address follows pc live; it is only committed on handshake.
   assign imem_req_addr = pc;

   ysyx_23060332_pc_reg #(
      .XLEN     (XLEN),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk            (clk),
      .rst_n          (rst_n),
      .advance        (pc_advance),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .pc             (pc),
      .misalign       (fetch_misalign)
   );

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: state_next = S_REQ;
         S_REQ: begin
            if (req_hs) begin
               state_next = redirect_valid ? S_FLUSH : S_WAIT;
            end
         end
         S_WAIT: begin
            if (rsp_hs) begin
               state_next = redirect_valid ? S_REQ : S_OUT;
            end else if (redirect_valid) begin
               state_next = S_FLUSH;
            end
         end
         S_OUT: begin
            if (redirect_valid || out_hs) begin
               state_next = S_REQ;
            end
         end
         // A redirect here only moves pc; the stale response must still drain.
         S_FLUSH: begin
            if (rsp_hs) begin
               state_next = S_REQ;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         imem_req_valid <= 1'b0;
         imem_rsp_ready <= 1'b0;
         inst_valid     <= 1'b0;
         inst_o         <= XLEN'(INST_NOP);
         inst_addr      <= RESET_PC;
      end else begin
         state          <= state_next;
         imem_req_valid <= drives_req(state_next);
         imem_rsp_ready <= takes_rsp(state_next);
         inst_valid     <= presents_inst(state_next);
         if (capture) begin
            inst_o    <= imem_rsp_data;
            inst_addr <= pc;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// Directed bench for the fetch unit: the bench plays imem and IDU by hand and
// checks every output against hand-derived values.
module tb_ysyx_23060332_ifu;

   logic        clk;
   logic        rst_n;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid, imem_rsp_ready;
   logic [31:0] imem_rsp_data;
   logic        inst_valid, inst_ready;
   logic [31:0] inst_o, inst_addr;
   logic        redirect_valid;
   logic [31:0] redirect_addr;
   logic        fetch_misalign;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] last_inst, last_addr;

   ysyx_23060332_ifu dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_ready (imem_rsp_ready),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_o         (inst_o),
      .inst_addr      (inst_addr),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .fetch_misalign (fetch_misalign)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Memory contents: low address bits placed in the immediate field of an addi.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[11:0], 20'h00093};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      while (!imem_req_valid && n < 20) begin
         tick();
         n++;
      end
      if (!imem_req_valid) check({tag, "_req_timeout"}, 32'(imem_req_valid), 32'd1);
   endtask

   // One full fetch: request handshake, lat cycles to response, instruction presented.
   task automatic do_fetch(input string tag, input logic [31:0] exp_addr, input int lat);
      wait_req(tag);
      check({tag, "_req_addr"}, imem_req_addr, exp_addr);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      repeat (lat - 1) tick();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(exp_addr);
      tick();
      imem_rsp_valid = 1'b0;
      last_inst = mem_word(exp_addr);
      last_addr = exp_addr;
      check({tag, "_inst_valid"}, 32'(inst_valid), 32'd1);
      check({tag, "_inst_o"}, inst_o, last_inst);
      check({tag, "_inst_addr"}, inst_addr, last_addr);
   endtask

   task automatic consume();
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      redirect_addr  = 32'h0;
      repeat (2) tick();

      check("rst_inst_valid", 32'(inst_valid), 32'd0);
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_rsp_ready", 32'(imem_rsp_ready), 32'd0);
      check("rst_inst_o", inst_o, 32'h0000_0013);
      check("rst_inst_addr", inst_addr, 32'h8000_0000);
      check("rst_misalign", 32'(fetch_misalign), 32'd0);

      // First fetch: request one cycle after release, inst_valid two edges later.
      rst_n = 1'b1;
      tick();
      check("first_req_valid", 32'(imem_req_valid), 32'd1);
      check("first_req_addr", imem_req_addr, 32'h8000_0000);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      check("first_wait_req_valid", 32'(imem_req_valid), 32'd0);
      check("first_wait_rsp_ready", 32'(imem_rsp_ready), 32'd1);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0000_0093;
      tick();
      imem_rsp_valid = 1'b0;
      check("first_inst_valid", 32'(inst_valid), 32'd1);
      check("first_inst_o", inst_o, 32'h0000_0093);
      check("first_inst_addr", inst_addr, 32'h8000_0000);
      consume();

      // Back-to-back sequential fetches.
      do_fetch("seq1", 32'h8000_0004, 1);
      consume();
      do_fetch("seq2", 32'h8000_0008, 1);

      // IDU stall: everything held, no new request.
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_inst_valid", 32'(inst_valid), 32'd1);
         check("stall_inst_o", inst_o, 32'h0080_0093);
         check("stall_inst_addr", inst_addr, 32'h8000_0008);
         check("stall_req_valid", 32'(imem_req_valid), 32'd0);
      end
      consume();

      // Redirect while waiting; stale response arrives later and is dropped.
      wait_req("flush");
      check("flush_req_addr_pre", imem_req_addr, 32'h8000_000C);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_addr  = 32'h8000_0100;
      tick();
      redirect_valid = 1'b0;
      check("flush_rsp_ready", 32'(imem_rsp_ready), 32'd1);
      check("flush_req_valid", 32'(imem_req_valid), 32'd0);
      tick();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
      tick();
      imem_rsp_valid = 1'b0;
      check("flush_inst_valid", 32'(inst_valid), 32'd0);
      check("flush_inst_o_kept", inst_o, last_inst);
      check("flush_req_valid_post", 32'(imem_req_valid), 32'd1);
      check("flush_req_addr", imem_req_addr, 32'h8000_0100);

      // Redirect in S_OUT alongside inst_ready: instruction dropped, no pc+4.
      do_fetch("tgt100", 32'h8000_0100, 1);
      inst_ready     = 1'b1;
      redirect_valid = 1'b1;
      redirect_addr  = 32'h8000_0200;
      tick();
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      check("outredir_inst_valid", 32'(inst_valid), 32'd0);
      check("outredir_req_valid", 32'(imem_req_valid), 32'd1);
      check("outredir_req_addr", imem_req_addr, 32'h8000_0200);

      // Misaligned redirect while a request is pending but not accepted.
      redirect_valid = 1'b1;
      redirect_addr  = 32'h8000_0102;
      tick();
      redirect_valid = 1'b0;
      check("misalign_pulse", 32'(fetch_misalign), 32'd1);
      check("misalign_req_addr", imem_req_addr, 32'h8000_0100);
      check("misalign_req_valid", 32'(imem_req_valid), 32'd1);
      tick();
      check("misalign_clear", 32'(fetch_misalign), 32'd0);

      // PC wrap at the top of the address space.
      redirect_valid = 1'b1;
      redirect_addr  = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      check("wrap_no_misalign", 32'(fetch_misalign), 32'd0);
      do_fetch("wrap_top", 32'hFFFF_FFFC, 2);
      consume();
      wait_req("wrap");
      check("wrap_req_addr", imem_req_addr, 32'h0000_0000);

      // Redirect in S_WAIT on the same cycle as the response: data dropped.
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h1234_5678;
      redirect_valid = 1'b1;
      redirect_addr  = 32'h8000_0300;
      tick();
      imem_rsp_valid = 1'b0;
      redirect_valid = 1'b0;
      check("waitrsp_inst_valid", 32'(inst_valid), 32'd0);
      check("waitrsp_inst_o_kept", inst_o, last_inst);
      check("waitrsp_req_addr", imem_req_addr, 32'h8000_0300);

      // Redirect on the request handshake cycle: goes through S_FLUSH.
      imem_req_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_addr  = 32'h8000_0400;
      tick();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b0;
      check("reqredir_rsp_ready", 32'(imem_rsp_ready), 32'd1);
      check("reqredir_req_valid", 32'(imem_req_valid), 32'd0);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hCAFE_F00D;
      tick();
      imem_rsp_valid = 1'b0;
      check("reqredir_inst_valid", 32'(inst_valid), 32'd0);
      check("reqredir_req_addr", imem_req_addr, 32'h8000_0400);
      do_fetch("tgt400", 32'h8000_0400, 1);

      // Reset mid-operation.
      rst_n = 1'b0;
      tick();
      check("midrst_inst_valid", 32'(inst_valid), 32'd0);
      check("midrst_inst_o", inst_o, 32'h0000_0013);
      check("midrst_inst_addr", inst_addr, 32'h8000_0000);
      check("midrst_req_valid", 32'(imem_req_valid), 32'd0);
      rst_n = 1'b1;
      tick();
      check("midrst_req_addr", imem_req_addr, 32'h8000_0000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
